// File: rtl/corefifo_gray_ptr_sync.sv
// corefifo_gray_ptr_sync: multi-channel Gray pointer synchroniser with
// binary decode, per-cycle advance delta and illegal-step detection.
module corefifo_gray_ptr_sync #(
    parameter int NUM_STAGES = 2,
    parameter int ADDRWIDTH  = 3,
    parameter int NUM_CH     = 1,
    parameter int PIPE_DEC   = 1
) (
    input  logic                            clk,
    input  logic                            arstn,
    input  logic                            srstn,
    input  logic [NUM_CH*(ADDRWIDTH+1)-1:0] inp,
    input  logic [NUM_CH-1:0]               err_clr,
    output logic [NUM_CH*(ADDRWIDTH+1)-1:0] sync_gray,
    output logic [NUM_CH*(ADDRWIDTH+1)-1:0] sync_bin,
    output logic [NUM_CH*(ADDRWIDTH+1)-1:0] ptr_delta,
    output logic [NUM_CH-1:0]               ptr_adv,
    output logic [NUM_CH-1:0]               gray_err,
    output logic                            warm
);
    localparam int PW = ADDRWIDTH + 1;
    localparam int WU = NUM_STAGES + PIPE_DEC + 1;
    localparam int CW = $clog2(NUM_STAGES + PIPE_DEC + 2);

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [CW-1:0] wcnt;

    assign warm = (wcnt == CW'(WU));

    // Warm-up counter, saturating once the pipeline holds real data
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn)
            wcnt <= '0;
        else if (!srstn)
            wcnt <= '0;
        else if (!warm)
            wcnt <= wcnt + CW'(1);
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [PW-1:0] stg [NUM_STAGES];
        logic [PW-1:0] gray;
        logic [PW-1:0] bin;
        logic [PW-1:0] prev_bin;
        logic [PW-1:0] prev_gray;
        logic [PW-1:0] flips;
        logic [PW-1:0] delta;
        logic          multi;
        logic          err;

        assign gray  = stg[NUM_STAGES-1];
        assign flips = gray ^ prev_gray;
        assign multi = |(flips & (flips - PW'(1)));
        assign delta = warm ? (bin - prev_bin) : '0;

        // Synchroniser flop chain
        always_ff @(posedge clk or negedge arstn) begin
            if (!arstn) begin
                for (int i = 0; i < NUM_STAGES; i++)
                    stg[i] <= '0;
            end else if (!srstn) begin
                for (int i = 0; i < NUM_STAGES; i++)
                    stg[i] <= '0;
            end else begin
                stg[0] <= inp[c*PW +: PW];
                for (int i = 1; i < NUM_STAGES; i++)
                    stg[i] <= stg[i-1];
            end
        end

        if (PIPE_DEC != 0) begin : g_pipe
            logic [PW-1:0] bin_q;

            // Registered Gray-to-binary decode
            always_ff @(posedge clk or negedge arstn) begin
                if (!arstn)
                    bin_q <= '0;
                else if (!srstn)
                    bin_q <= '0;
                else
                    bin_q <= gray2bin(gray);
            end

            assign bin = bin_q;
        end else begin : g_comb
            assign bin = gray2bin(gray);
        end

        // Previous-sample history and sticky error; a set beats a clear
        always_ff @(posedge clk or negedge arstn) begin
            if (!arstn) begin
                prev_bin  <= '0;
                prev_gray <= '0;
                err       <= 1'b0;
            end else if (!srstn) begin
                prev_bin  <= '0;
                prev_gray <= '0;
                err       <= 1'b0;
            end else begin
                prev_bin  <= bin;
                prev_gray <= gray;
                err       <= (warm & multi) | (err & ~err_clr[c]);
            end
        end

        assign sync_gray[c*PW +: PW] = gray;
        assign sync_bin[c*PW +: PW]  = bin;
        assign ptr_delta[c*PW +: PW] = delta;
        assign ptr_adv[c]            = |delta;
        assign gray_err[c]           = err;
    end

endmodule
